sev_seg_multi_display: RTL and testbench
========================================

// Module: sev_seg_multi_display
// PURPOSE
//   Registered, parametrised N-digit 7-segment driver for the stopwatch display path on DE10 HEX LEDs.
//   Takes packed BCD digits plus a load strobe, latches them, and drives per-digit segment patterns.
//   Adds features the fixed 4-digit decoder lacks: DP merged into any digit, leading-zero blanking,
//   lap-hold freeze, timed blink and output polarity select.
//   Sits between the stopwatch counter and the HEX pins.
// PARAMETERS
//   NUM_DIGITS   6           number of displayed digits; index 0 = rightmost
//   DP_POS       1           digit whose DP segment (bit 7) is lit; must be < NUM_DIGITS
//   CLK_HZ       50_000_000  clk frequency in Hz
//   BLINK_HZ     2           blink rate in Hz; half-period HALF = CLK_HZ/(2*BLINK_HZ), must be >= 1
//   ACTIVE_LOW   1           1 = common-anode patterns (0 = segment on); 0 = all output bits inverted
// PORTS
//   clk        in   1             system clock; all state on rising edge
//   reset_n    in   1             asynchronous, active-low reset
//   digits_i   in   4*NUM_DIGITS  packed BCD; digit i = digits_i[4i+3:4i]
//   valid_i    in   1             load strobe for digits_i
//   hold_i     in   1             lap freeze: while high, valid_i is ignored
//   blink_i    in   1             blink enable
//   blank_lz_i in   1             leading-zero suppression enable
//   HEX        out  [7:0] x [0:NUM_DIGITS-1]  registered segment patterns; bit7 = DP, bits 6:0 = g..a
// BEHAVIOUR
//   - Reset (async, reset_n=0): capture reg = 0, blink counter = 0, blink phase = VISIBLE,
//     every HEX = all segments off (8'hFF when ACTIVE_LOW=1, 8'h00 otherwise).
//   - Capture: on a clk edge with valid_i=1 and hold_i=0, the capture reg loads digits_i.
//     hold_i=1 blocks the load, including when valid_i is high in the same cycle.
//   - Output: the HEX reg updates every cycle from the capture reg.
//     Latency from valid_i sampled to HEX = 2 clk edges.
//     The first edge after reset release shows the decoded capture reg, i.e. all zeros.
//   - Decode per digit:
//       0-9   -> standard common-anode patterns (0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90)
//       10-15 -> DASH 8'hBF
//   - DP: bit 7 is forced on (0 when active-low) for digit DP_POS only, unless that digit is blanked.
//   - Leading-zero blank (blank_lz_i=1): digit i > DP_POS is blanked when it and every higher digit are 0.
//     Digits <= DP_POS are never blanked by this rule.
//   - Blink counter:
//       blink_i=1: counts 0..HALF-1, wraps to 0 and toggles phase at HALF-1.
//       blink_i=0: counter held at 0, phase forced VISIBLE, so the next blink starts visible for a full HALF.
//   - Blank phase: all digits off, including DP.
//   - Polarity: ACTIVE_LOW=0 inverts the final 8-bit pattern after all blanking.
//   - Reset mid-operation: immediate all-off outputs; capture contents lost.
//   - Elaboration: $error if DP_POS >= NUM_DIGITS or HALF < 1.
// CONFIGURATION
//   SEV_SEG_HEX_EN defined:     codes 10-15 decode to hex glyphs
//                               A=88, b=83, C=C6, d=A1, E=86, F=8E (active-low).
//   SEV_SEG_HEX_EN not defined: codes 10-15 decode to DASH 8'hBF.
//   All other behaviour is identical in both builds.
// STRUCTURE
//   sev_seg_pkg:
//     - segment constants ZERO..NINE, DASH, DOT_MASK, SEG_OFF, hex glyphs
//     - typedef logic [3:0] bcd_t
//     - typedef logic [7:0] seg_t
//   sev_seg_digit_dec: combinational sub-module, bcd_t -> seg_t; instanced per digit in a generate loop.
//   Top level holds the capture reg, the LZ chain (MSB-down "all higher zero" carry),
//   the blink counter/phase and the output regs.
// TESTING  (NUM_DIGITS=4, DP_POS=1, CLK_HZ=8, BLINK_HZ=1 -> HALF=4 unless noted)
//   1. reset_n=0 mid-run -> HEX all 8'hFF immediately.
//      Release -> one edge later HEX = {C0,C0,40,C0} (blank_lz_i=0).
//   2. digits_i=16'h0537, valid_i pulse, blank_lz_i=0 -> 2 edges later HEX[3..0] = C0,92,30,F8.
//      Same with blank_lz_i=1 -> HEX[3]=FF.
//   3. digits_i=16'h0000, blank_lz_i=1 -> HEX[3..0] = FF,FF,40,C0.
//      digits_i=16'h0900 -> C0 not blanked at HEX[2]? No: HEX[3]=FF, HEX[2]=90.
//   4. Load 16'h1234; hold_i=1 with valid_i on 16'h5678 -> HEX stays F9,A4,30,99.
//      Drop hold_i, pulse valid_i -> 5678 shown 2 edges later.
//   5. blink_i=1 -> 4 cycles visible, 4 cycles all-FF, repeating.
//      Drop blink_i in blank phase -> visible on the next edge.
//      Reassert blink_i -> full 4 visible cycles first.
//   6. digits_i=16'h00A0 -> HEX[1] = BF & 7F = 3F.
//      With SEV_SEG_HEX_EN -> 88 & 7F = 08.
//      ACTIVE_LOW=0 rerun of scenario 2 -> bitwise inverse.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// rtl/sev_seg_pkg.sv - shared types, segment constants and helpers for the 7-segment display path
package sev_seg_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [7:0] seg_t;

    // Common-anode (active-low) patterns, bit7 = DP, bits 6:0 = g..a
    localparam seg_t SEG_ZERO  = 8'hC0;
    localparam seg_t SEG_ONE   = 8'hF9;
    localparam seg_t SEG_TWO   = 8'hA4;
    localparam seg_t SEG_THREE = 8'hB0;
    localparam seg_t SEG_FOUR  = 8'h99;
    localparam seg_t SEG_FIVE  = 8'h92;
    localparam seg_t SEG_SIX   = 8'h82;
    localparam seg_t SEG_SEVEN = 8'hF8;
    localparam seg_t SEG_EIGHT = 8'h80;
    localparam seg_t SEG_NINE  = 8'h90;
    localparam seg_t SEG_DASH  = 8'hBF;
    localparam seg_t SEG_OFF   = 8'hFF;
    localparam seg_t DOT_MASK  = 8'h7F;

    // Hex glyphs for codes 10..15
    localparam seg_t SEG_HEX_A = 8'h88;
    localparam seg_t SEG_HEX_B = 8'h83;
    localparam seg_t SEG_HEX_C = 8'hC6;
    localparam seg_t SEG_HEX_D = 8'hA1;
    localparam seg_t SEG_HEX_E = 8'h86;
    localparam seg_t SEG_HEX_F = 8'h8E;

    typedef enum logic {
        PHASE_VISIBLE = 1'b0,
        PHASE_BLANK   = 1'b1
    } blink_phase_e;

    // Lights the decimal point of an active-low pattern
    function automatic seg_t seg_with_dp(input seg_t s);
        return s & DOT_MASK;
    endfunction

endpackage

// File: rtl/sev_seg_digit_dec.sv
// rtl/sev_seg_digit_dec.sv - combinational BCD to active-low 7-segment decoder for one digit
//
// Ports:
//   bcd_i  in   bcd_t  digit code 0..15
//   seg_o  out  seg_t  active-low pattern, DP (bit 7) always off
// Config macro: SEV_SEG_HEX_EN selects hex glyphs for codes 10..15, otherwise a dash.
module sev_seg_digit_dec
    import sev_seg_pkg::*;
(
    input  bcd_t bcd_i,
    output seg_t seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_ZERO;
            4'd1:    seg_o = SEG_ONE;
            4'd2:    seg_o = SEG_TWO;
            4'd3:    seg_o = SEG_THREE;
            4'd4:    seg_o = SEG_FOUR;
            4'd5:    seg_o = SEG_FIVE;
            4'd6:    seg_o = SEG_SIX;
            4'd7:    seg_o = SEG_SEVEN;
            4'd8:    seg_o = SEG_EIGHT;
            4'd9:    seg_o = SEG_NINE;
`ifdef SEV_SEG_HEX_EN
            4'd10:   seg_o = SEG_HEX_A;
            4'd11:   seg_o = SEG_HEX_B;
            4'd12:   seg_o = SEG_HEX_C;
            4'd13:   seg_o = SEG_HEX_D;
            4'd14:   seg_o = SEG_HEX_E;
            4'd15:   seg_o = SEG_HEX_F;
`else
            default: seg_o = SEG_DASH;
`endif
        endcase
    end

endmodule

// File: rtl/sev_seg_multi_display.sv
// rtl/sev_seg_multi_display.sv - registered N-digit 7-segment driver with DP, leading-zero blank, hold, blink, polarity
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   digits_i    in   packed BCD, digit i = digits_i[4i+3:4i], digit 0 rightmost
//   valid_i     in   load strobe for digits_i
//   hold_i      in   lap freeze, blocks valid_i while high
//   blink_i     in   blink enable
//   blank_lz_i  in   leading-zero suppression enable
//   HEX         out  registered per-digit patterns, bit7 = DP, bits 6:0 = g..a
// Config macro: SEV_SEG_HEX_EN (hex glyphs for codes 10..15, passed to the digit decoder).
module sev_seg_multi_display
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int DP_POS     = 1,
    parameter int CLK_HZ     = 50_000_000,
    parameter int BLINK_HZ   = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    valid_i,
    input  logic                    hold_i,
    input  logic                    blink_i,
    input  logic                    blank_lz_i,
    output logic [7:0]              HEX [0:NUM_DIGITS-1]
);

    localparam int   HALF      = CLK_HZ / (2 * BLINK_HZ);
    localparam int   CNT_W     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);
    // Level driven on the pins when everything is dark
    localparam seg_t OFF_LEVEL = (ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;

    if (DP_POS >= NUM_DIGITS) begin : g_bad_dp_pos
        $error("sev_seg_multi_display: DP_POS must be below NUM_DIGITS");
    end
    if (HALF < 1) begin : g_bad_half
        $error("sev_seg_multi_display: blink half-period must be at least one cycle");
    end

    // ------------------------------------------------------------------
    // Capture register
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] cap_q, cap_d;

    always_comb begin
        cap_d = cap_q;
        if (valid_i && !hold_i) begin
            cap_d = digits_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q <= '0;
        end else begin
            cap_q <= cap_d;
        end
    end

    // ------------------------------------------------------------------
    // Blink counter and phase
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    blink_phase_e     phase_q, phase_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= PHASE_VISIBLE;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!blink_i) begin
            // Parked so the next blink run starts with a full visible half-period
            cnt_d   = '0;
            phase_d = PHASE_VISIBLE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = (phase_q == PHASE_VISIBLE) ? PHASE_BLANK : PHASE_VISIBLE;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Gated by blink_i so dropping blink in the dark phase lights the next edge
    logic blink_off;
    assign blink_off = blink_i && (phase_q == PHASE_BLANK);

    // ------------------------------------------------------------------
    // Per-digit decode
    // ------------------------------------------------------------------
    seg_t dec [NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        sev_seg_digit_dec u_dec (
            .bcd_i (cap_q[4*g +: 4]),
            .seg_o (dec[g])
        );
    end

    // ------------------------------------------------------------------
    // Leading-zero chain: carry "this and all higher digits are zero" downward
    // ------------------------------------------------------------------
    logic                  higher_zero;
    logic [NUM_DIGITS-1:0] lz_blank;

    always_comb begin
        higher_zero = 1'b1;
        lz_blank    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero && (cap_q[4*i +: 4] == 4'd0);
            if (blank_lz_i && (i > DP_POS) && higher_zero) begin
                lz_blank[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output composition and registers
    // ------------------------------------------------------------------
    seg_t hex_d [NUM_DIGITS];
    seg_t hex_q [NUM_DIGITS];

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_d[i] = dec[i];
            if (i == DP_POS) begin
                hex_d[i] = seg_with_dp(hex_d[i]);
            end
            if (lz_blank[i] || blink_off) begin
                hex_d[i] = SEG_OFF;
            end
            // Polarity is applied last so blanking always means dark
            if (ACTIVE_LOW == 0) begin
                hex_d[i] = ~hex_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= OFF_LEVEL;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            HEX[i] = hex_q[i];
        end
    end

endmodule

// File: tb/tb_sev_seg_multi_display.sv
// tb/tb_sev_seg_multi_display.sv - directed self-checking bench for sev_seg_multi_display
module tb_sev_seg_multi_display;

    logic        clk;
    logic        reset_n;
    logic [15:0] digits;
    logic        valid;
    logic        hold;
    logic        blink;
    logic        blank_lz;
    logic [7:0]  hex   [0:3];
    logic [7:0]  hex_n [0:3];

    int n_checks;
    int n_fail;

    wire [31:0] hex_all   = {hex[3], hex[2], hex[1], hex[0]};
    wire [31:0] hex_n_all = {hex_n[3], hex_n[2], hex_n[1], hex_n[0]};

    sev_seg_multi_display #(
        .NUM_DIGITS (4),
        .DP_POS     (1),
        .CLK_HZ     (8),
        .BLINK_HZ   (1),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .digits_i   (digits),
        .valid_i    (valid),
        .hold_i     (hold),
        .blink_i    (blink),
        .blank_lz_i (blank_lz),
        .HEX        (hex)
    );

    sev_seg_multi_display #(
        .NUM_DIGITS (4),
        .DP_POS     (1),
        .CLK_HZ     (8),
        .BLINK_HZ   (1),
        .ACTIVE_LOW (0)
    ) dut_inv (
        .clk        (clk),
        .reset_n    (reset_n),
        .digits_i   (digits),
        .valid_i    (valid),
        .hold_i     (hold),
        .blink_i    (blink),
        .blank_lz_i (blank_lz),
        .HEX        (hex_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] d);
        digits = d;
        valid  = 1'b1;
        step();
        valid  = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step();
        n_checks++;
        if (hex_all !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h", hex_all, 32'hFFFFFFFF);
        end
        n_checks++;
        if (hex_n_all !== 32'h00000000) begin
            n_fail++;
            $display("FAIL reset_hold_inv: got %h want %h", hex_n_all, 32'h00000000);
        end
        reset_n = 1'b1;
        step();
        n_checks++;
        if (hex_all !== 32'hC0C040C0) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", hex_all, 32'hC0C040C0);
        end
        load(16'h1234);
        n_checks++;
        if (hex_all !== 32'hF9A43099) begin
            n_fail++;
            $display("FAIL pre_midrun: got %h want %h", hex_all, 32'hF9A43099);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (hex_all !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL midrun_reset_async: got %h want %h", hex_all, 32'hFFFFFFFF);
        end
        step();
        reset_n = 1'b1;
        step();
        n_checks++;
        if (hex_all !== 32'hC0C040C0) begin
            n_fail++;
            $display("FAIL midrun_contents_lost: got %h want %h", hex_all, 32'hC0C040C0);
        end
    endtask

    task automatic test_capture();
        digits = 16'h0537;
        valid  = 1'b1;
        step();
        valid  = 1'b0;
        n_checks++;
        if (hex_all !== 32'hC0C040C0) begin
            n_fail++;
            $display("FAIL latency_one_edge: got %h want %h", hex_all, 32'hC0C040C0);
        end
        step();
        n_checks++;
        if (hex_all !== 32'hC09230F8) begin
            n_fail++;
            $display("FAIL capture_0537: got %h want %h", hex_all, 32'hC09230F8);
        end
        n_checks++;
        if (hex_n_all !== 32'h3F6DCF07) begin
            n_fail++;
            $display("FAIL capture_0537_inv: got %h want %h", hex_n_all, 32'h3F6DCF07);
        end
        blank_lz = 1'b1;
        step();
        n_checks++;
        if (hex_all !== 32'hFF9230F8) begin
            n_fail++;
            $display("FAIL lz_0537: got %h want %h", hex_all, 32'hFF9230F8);
        end
        n_checks++;
        if (hex_n_all !== 32'h006DCF07) begin
            n_fail++;
            $display("FAIL lz_0537_inv: got %h want %h", hex_n_all, 32'h006DCF07);
        end
    endtask

    task automatic test_lz();
        blank_lz = 1'b1;
        load(16'h0000);
        n_checks++;
        if (hex_all !== 32'hFFFF40C0) begin
            n_fail++;
            $display("FAIL lz_0000: got %h want %h", hex_all, 32'hFFFF40C0);
        end
        load(16'h0900);
        n_checks++;
        if (hex_all !== 32'hFF9040C0) begin
            n_fail++;
            $display("FAIL lz_0900: got %h want %h", hex_all, 32'hFF9040C0);
        end
        blank_lz = 1'b0;
        step();
        n_checks++;
        if (hex_all !== 32'hC09040C0) begin
            n_fail++;
            $display("FAIL nolz_0900: got %h want %h", hex_all, 32'hC09040C0);
        end
    endtask

    task automatic test_hold();
        load(16'h1234);
        hold   = 1'b1;
        digits = 16'h5678;
        valid  = 1'b1;
        step();
        step();
        step();
        n_checks++;
        if (hex_all !== 32'hF9A43099) begin
            n_fail++;
            $display("FAIL hold_blocks_load: got %h want %h", hex_all, 32'hF9A43099);
        end
        hold  = 1'b0;
        valid = 1'b1;
        step();
        valid = 1'b0;
        n_checks++;
        if (hex_all !== 32'hF9A43099) begin
            n_fail++;
            $display("FAIL hold_release_latency: got %h want %h", hex_all, 32'hF9A43099);
        end
        step();
        n_checks++;
        if (hex_all !== 32'h92827880) begin
            n_fail++;
            $display("FAIL hold_release_5678: got %h want %h", hex_all, 32'h92827880);
        end
    endtask

    task automatic test_blink();
        logic [31:0] exp;
        load(16'h1234);
        blink = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step();
            exp = (((k / 4) % 2) == 0) ? 32'hF9A43099 : 32'hFFFFFFFF;
            n_checks++;
            if (hex_all !== exp) begin
                n_fail++;
                $display("FAIL blink_cycle_%0d: got %h want %h", k, hex_all, exp);
            end
        end
        blink = 1'b0;
        step();
        n_checks++;
        if (hex_all !== 32'hF9A43099) begin
            n_fail++;
            $display("FAIL blink_drop_visible: got %h want %h", hex_all, 32'hF9A43099);
        end
        blink = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            exp = (k < 4) ? 32'hF9A43099 : 32'hFFFFFFFF;
            n_checks++;
            if (hex_all !== exp) begin
                n_fail++;
                $display("FAIL blink_restart_%0d: got %h want %h", k, hex_all, exp);
            end
        end
        n_checks++;
        if (hex_n_all !== 32'h00000000) begin
            n_fail++;
            $display("FAIL blink_dark_inv: got %h want %h", hex_n_all, 32'h00000000);
        end
        blink = 1'b0;
        step();
    endtask

    task automatic test_code_a();
        logic [31:0] exp;
`ifdef SEV_SEG_HEX_EN
        exp = 32'hC0C008C0;
`else
        exp = 32'hC0C03FC0;
`endif
        blank_lz = 1'b0;
        load(16'h00A0);
        n_checks++;
        if (hex_all !== exp) begin
            n_fail++;
            $display("FAIL code_a_dp: got %h want %h", hex_all, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        digits   = 16'h0000;
        valid    = 1'b0;
        hold     = 1'b0;
        blink    = 1'b0;
        blank_lz = 1'b0;

        test_reset();
        test_capture();
        test_lz();
        test_hold();
        test_blink();
        test_code_a();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
